// File: rtl/can_pkg.sv
// can_pkg: shared definitions for the CAN bit-level receive front end.
//   - can_state_e : receiver state (INTEGRATE, IDLE, FRAME)
//   - bit timing defaults and the derived BIT_CLKS / SAMPLE_CLK
//   - stuffing / integration limits and bus level names
//   - in_resync_window(): true when a phase lies within sjw of the bit boundary
package can_pkg;

  typedef enum logic [1:0] {
    INTEGRATE = 2'd0,
    IDLE      = 2'd1,
    FRAME     = 2'd2
  } can_state_e;

  localparam int CLK_SPEED_MHZ      = 100;
  localparam int CAN_BIT_RATE_KBITS = 1000;
  localparam int SAMPLE_POINT_PCT   = 75;
  localparam int SJW_CLKS           = 20;

  localparam int BIT_CLKS   = CLK_SPEED_MHZ * 1000 / CAN_BIT_RATE_KBITS;
  localparam int SAMPLE_CLK = BIT_CLKS * SAMPLE_POINT_PCT / 100;

  localparam int STUFF_LIMIT    = 5;
  localparam int INTEGRATE_BITS = 11;

  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;

  // An edge close enough to the bit boundary (either side) may pull the phase.
  function automatic logic in_resync_window(input int phase, input int bit_clks,
                                            input int sjw);
    return ((phase < sjw) || (phase >= (bit_clks - sjw)));
  endfunction

endpackage

// File: rtl/can_rx_sync.sv
// can_rx_sync: two-flop synchroniser for the asynchronous CAN Rx pin plus
// recessive-to-dominant edge detection.
//   clk, rst_n : system clock, async active-low reset
//   rx         : raw Rx pin (1 = recessive)
//   rx_s       : synchronised Rx level
//   rx_edge    : high for one cycle when rx_s goes recessive -> dominant
module can_rx_sync
  import can_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic rx_edge
);

  logic sync1_r;
  logic sync2_r;
  logic rx_d_r;

  // Synchroniser chain and one-cycle delayed copy; idle bus level is recessive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= RECESSIVE;
      sync2_r <= RECESSIVE;
      rx_d_r  <= RECESSIVE;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
      rx_d_r  <= sync2_r;
    end
  end

  assign rx_s    = sync2_r;
  assign rx_edge = rx_d_r & ~sync2_r;

endmodule

// File: rtl/can_bit_sampler.sv
// can_bit_sampler: bit-level CAN receive front end.
// Integrates onto the bus (11 recessive bits), hard-syncs on SOF, resyncs on
// recessive-to-dominant edges, samples at the sample point and removes stuff
// bits. Frame end is signalled back by frame_length_calc via sample_en.
//   clk, rst_n  : system clock, async active-low reset
//   rx          : raw CAN Rx pin (1 = recessive)
//   sample_en   : from frame_length_calc, falling edge = end of frame
//   destuff_en  : current bit lies in the stuffed region
//   sof         : one-cycle pulse on hard sync
//   din/dvalid  : destuffed bit and its one-cycle valid strobe
//   stuff_err   : one-cycle pulse on a stuff rule violation
//   bus_idle    : high while in IDLE
module can_bit_sampler
  import can_pkg::*;
#(
  parameter int clk_speed_MHz      = CLK_SPEED_MHZ,
  parameter int can_bit_rate_Kbits = CAN_BIT_RATE_KBITS,
  parameter int sample_point_pct   = SAMPLE_POINT_PCT,
  parameter int sjw_clks           = SJW_CLKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  input  logic sample_en,
  input  logic destuff_en,
  output logic sof,
  output logic din,
  output logic dvalid,
  output logic stuff_err,
  output logic bus_idle
);

  localparam int P_BIT_CLKS   = clk_speed_MHz * 1000 / can_bit_rate_Kbits;
  localparam int P_SAMPLE_CLK = P_BIT_CLKS * sample_point_pct / 100;
  localparam int PW           = $clog2(P_BIT_CLKS);

  logic           rx_s;
  logic           rx_edge_s;
  logic           sample_s;
  logic           resync_s;
  logic           sen_fall_s;
  logic [PW-1:0]  phase_nxt_s;
  logic           deliver_s;
  logic           stuff_viol_s;
  logic [2:0]     same_cnt_nxt_s;
  logic           last_bit_nxt_s;

  can_state_e     state_r;
  logic [PW-1:0]  phase_r;
  logic [2:0]     same_cnt_r;
  logic           last_bit_r;
  logic [3:0]     rec_cnt_r;
  logic           first_bit_r;
  logic           armed_r;
  logic           sample_en_r;
  logic           sof_r;
  logic           din_r;
  logic           dvalid_r;
  logic           stuff_err_r;
  logic           bus_idle_r;

  can_rx_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_edge (rx_edge_s)
  );

  // Sample strobe, resync qualification and end-of-frame detect.
  always_comb begin
    sample_s   = (state_r != IDLE) && (phase_r == PW'(P_SAMPLE_CLK));
    resync_s   = rx_edge_s && in_resync_window(int'(phase_r), P_BIT_CLKS, sjw_clks);
    // armed_r ignores a low sample_en before it has risen in this frame.
    sen_fall_s = armed_r & sample_en_r & ~sample_en;
  end

  // Next phase: resync to the boundary, else count modulo BIT_CLKS.
  always_comb begin
    phase_nxt_s = '0;
    if (resync_s) begin
      phase_nxt_s = '0;
    end else if (phase_r == PW'(P_BIT_CLKS - 1)) begin
      phase_nxt_s = '0;
    end else begin
      phase_nxt_s = phase_r + PW'(1);
    end
  end

  // Destuffing decision for the bit currently on rx_s.
  always_comb begin
    deliver_s      = 1'b0;
    stuff_viol_s   = 1'b0;
    same_cnt_nxt_s = same_cnt_r;
    last_bit_nxt_s = last_bit_r;
    if (!destuff_en) begin
      deliver_s      = 1'b1;
      same_cnt_nxt_s = 3'd0;
    end else if (same_cnt_r == 3'(STUFF_LIMIT)) begin
      if (rx_s != last_bit_r) begin
        // Stuff bit: dropped, but it starts a new run.
        same_cnt_nxt_s = 3'd1;
        last_bit_nxt_s = rx_s;
      end else begin
        stuff_viol_s = 1'b1;
      end
    end else begin
      deliver_s = 1'b1;
      if (rx_s == last_bit_r) begin
        same_cnt_nxt_s = same_cnt_r + 3'd1;
      end else begin
        same_cnt_nxt_s = 3'd1;
        last_bit_nxt_s = rx_s;
      end
    end
  end

  // Receiver state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= INTEGRATE;
      phase_r     <= '0;
      same_cnt_r  <= 3'd0;
      last_bit_r  <= RECESSIVE;
      rec_cnt_r   <= 4'd0;
      first_bit_r <= 1'b0;
      armed_r     <= 1'b0;
      sample_en_r <= 1'b0;
      sof_r       <= 1'b0;
      din_r       <= 1'b1;
      dvalid_r    <= 1'b0;
      stuff_err_r <= 1'b0;
      bus_idle_r  <= 1'b0;
    end else begin
      sample_en_r <= sample_en;
      sof_r       <= 1'b0;
      dvalid_r    <= 1'b0;
      stuff_err_r <= 1'b0;
      case (state_r)
        INTEGRATE: begin
          phase_r <= phase_nxt_s;
          if (sample_s) begin
            if (rx_s == RECESSIVE) begin
              if (rec_cnt_r == 4'(INTEGRATE_BITS - 1)) begin
                state_r    <= IDLE;
                bus_idle_r <= 1'b1;
                phase_r    <= '0;
                rec_cnt_r  <= 4'd0;
              end else begin
                rec_cnt_r <= rec_cnt_r + 4'd1;
              end
            end else begin
              rec_cnt_r <= 4'd0;
            end
          end
        end

        IDLE: begin
          phase_r <= '0;
          if (rx_edge_s) begin
            // Hard sync on SOF.
            state_r     <= FRAME;
            sof_r       <= 1'b1;
            same_cnt_r  <= 3'd0;
            last_bit_r  <= RECESSIVE;
            first_bit_r <= 1'b1;
            armed_r     <= 1'b0;
            bus_idle_r  <= 1'b0;
          end
        end

        FRAME: begin
          phase_r <= phase_nxt_s;
          if (sample_en) begin
            armed_r <= 1'b1;
          end
          if (sample_s && first_bit_r && (rx_s != DOMINANT)) begin
            // SOF sampled recessive: treat the edge as a glitch.
            state_r    <= IDLE;
            bus_idle_r <= 1'b1;
            phase_r    <= '0;
          end else if (sample_s && stuff_viol_s) begin
            // Takes priority over a simultaneous sample_en fall.
            stuff_err_r <= 1'b1;
            state_r     <= INTEGRATE;
            rec_cnt_r   <= 4'd0;
          end else begin
            if (sample_s) begin
              first_bit_r <= 1'b0;
              same_cnt_r  <= same_cnt_nxt_s;
              last_bit_r  <= last_bit_nxt_s;
              if (deliver_s) begin
                dvalid_r <= 1'b1;
                din_r    <= rx_s;
              end
            end
            if (sen_fall_s) begin
              state_r    <= IDLE;
              bus_idle_r <= 1'b1;
              phase_r    <= '0;
            end
          end
        end

        default: begin
          state_r <= INTEGRATE;
        end
      endcase
    end
  end

  assign sof       = sof_r;
  assign din       = din_r;
  assign dvalid    = dvalid_r;
  assign stuff_err = stuff_err_r;
  assign bus_idle  = bus_idle_r;

endmodule

// File: tb/tb_can_bit_sampler.sv
// Self-checking bench for can_bit_sampler. Expected destuffed bits are pushed
// to a queue as rx bits are driven; a negedge monitor pops and compares on
// every dvalid. Scenario tasks check timing, counts and status outputs.
module tb_can_bit_sampler;

  logic clk;
  logic rst_n;
  logic rx;
  logic sample_en;
  logic destuff_en;
  logic sof;
  logic din;
  logic dvalid;
  logic stuff_err;
  logic bus_idle;

  int tests_run    = 0;
  int tests_failed = 0;
  int sof_cnt      = 0;
  int dv_cnt       = 0;
  int serr_cnt     = 0;
  logic exp_q[$];

  can_bit_sampler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .sample_en  (sample_en),
    .destuff_en (destuff_en),
    .sof        (sof),
    .din        (din),
    .dvalid     (dvalid),
    .stuff_err  (stuff_err),
    .bus_idle   (bus_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: pulse counting, exclusivity and din checking.
  always @(negedge clk) begin
    logic e;
    if (rst_n) begin
      if (sof) sof_cnt++;
      if (stuff_err) serr_cnt++;
      if (sof || dvalid || stuff_err) begin
        tests_run++;
        if ((int'(sof) + int'(dvalid) + int'(stuff_err)) > 1) begin
          tests_failed++;
          $display("FAIL pulse_exclusive: got sof=%b dvalid=%b stuff_err=%b, expected at most one high",
                   sof, dvalid, stuff_err);
        end
      end
      if (dvalid) begin
        dv_cnt++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL dvalid_unexpected: got dvalid with din=%b, expected no dvalid", din);
        end else begin
          e = exp_q.pop_front();
          if (din !== e) begin
            tests_failed++;
            $display("FAIL din_value: got %b, expected %b (dvalid #%0d)", din, e, dv_cnt);
          end
        end
      end
    end
  end

  task automatic send_bit(input logic b, input bit expect_dv, input int clks);
    if (expect_dv) exp_q.push_back(b);
    rx = b;
    repeat (clks) @(negedge clk);
  endtask

  task automatic check_int(input string name, input int got, input int exp_v);
    // kept inline-style: used only for simple equality of counters
    tests_run++;
    if (got !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp_v);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; sample_en = 1'b0; destuff_en = 1'b1;
    repeat (5) @(negedge clk);
    tests_run++;
    if (sof !== 1'b0) begin tests_failed++; $display("FAIL reset_sof: got %b, expected 0", sof); end
    tests_run++;
    if (din !== 1'b1) begin tests_failed++; $display("FAIL reset_din: got %b, expected 1", din); end
    tests_run++;
    if (dvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_dvalid: got %b, expected 0", dvalid); end
    tests_run++;
    if (stuff_err !== 1'b0) begin tests_failed++; $display("FAIL reset_stuff_err: got %b, expected 0", stuff_err); end
    tests_run++;
    if (bus_idle !== 1'b0) begin tests_failed++; $display("FAIL reset_bus_idle: got %b, expected 0", bus_idle); end
    rst_n = 1'b1;
  endtask

  task automatic test_integrate();
    int s0 = sof_cnt;
    int d0 = dv_cnt;
    int lat = 0;
    for (int i = 1; i <= 1300; i++) begin
      @(negedge clk);
      if (i == 1000) begin
        tests_run++;
        if (bus_idle !== 1'b0) begin tests_failed++; $display("FAIL integrate_early: got bus_idle=%b at 1000 clk, expected 0", bus_idle); end
      end
      if (bus_idle && lat == 0) lat = i;
    end
    tests_run++;
    if (lat < 1060 || lat > 1100) begin
      tests_failed++;
      $display("FAIL integrate_time: got bus_idle at %0d clk, expected 1060..1100", lat);
    end
    check_int("integrate_no_sof", sof_cnt - s0, 0);
    check_int("integrate_no_dvalid", dv_cnt - d0, 0);
  endtask

  task automatic test_frame();
    logic [10:0] id = 11'h123;
    int s0 = sof_cnt;
    int d0 = dv_cnt;
    int sof_lat = 0;
    int dv_lat = 0;
    destuff_en = 1'b1; sample_en = 1'b0;
    exp_q.push_back(1'b0);
    rx = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (sof && sof_lat == 0) sof_lat = i;
      if (dvalid && dv_lat == 0) dv_lat = i;
    end
    check_int("frame_sof_latency", sof_lat, 3);
    tests_run++;
    if (dv_lat < 76 || dv_lat > 82) begin
      tests_failed++;
      $display("FAIL frame_first_dvalid: got latency %0d clk, expected 76..82", dv_lat);
    end
    sample_en = 1'b1;
    for (int i = 10; i >= 0; i--) send_bit(id[i], 1'b1, 100);
    // Outside the stuffed region a long recessive run must pass unchanged.
    destuff_en = 1'b0;
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b1, 100);
    sample_en = 1'b0;
    repeat (5) @(negedge clk);
    destuff_en = 1'b1;
    tests_run++;
    if (bus_idle !== 1'b1) begin tests_failed++; $display("FAIL frame_end_idle: got bus_idle=%b, expected 1", bus_idle); end
    check_int("frame_dvalid_count", dv_cnt - d0, 19);
    check_int("frame_sof_count", sof_cnt - s0, 1);
    check_int("frame_queue_empty", exp_q.size(), 0);
  endtask

  task automatic test_destuff();
    int d0 = dv_cnt;
    int e0 = serr_cnt;
    send_bit(1'b0, 1'b1, 100);
    sample_en = 1'b1;
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1, 100);
    send_bit(1'b1, 1'b0, 100);
    send_bit(1'b0, 1'b1, 100);
    rx = 1'b1; sample_en = 1'b0;
    repeat (5) @(negedge clk);
    check_int("destuff_dvalid_count", dv_cnt - d0, 6);
    check_int("destuff_no_err", serr_cnt - e0, 0);
    check_int("destuff_queue_empty", exp_q.size(), 0);
    tests_run++;
    if (bus_idle !== 1'b1) begin tests_failed++; $display("FAIL destuff_end_idle: got bus_idle=%b, expected 1", bus_idle); end
  endtask

  task automatic test_stuff_err();
    int d0 = dv_cnt;
    int e0 = serr_cnt;
    int lat = 0;
    int idle_lat = 0;
    send_bit(1'b0, 1'b1, 100);
    sample_en = 1'b1;
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1, 100);
    rx = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (stuff_err && lat == 0) lat = i;
    end
    tests_run++;
    if (lat < 77 || lat > 81) begin
      tests_failed++;
      $display("FAIL stuff_err_time: got pulse at %0d clk into 6th bit, expected 77..81", lat);
    end
    rx = 1'b1; sample_en = 1'b0;
    check_int("stuff_err_count", serr_cnt - e0, 1);
    check_int("stuff_err_dvalid_count", dv_cnt - d0, 5);
    for (int i = 1; i <= 1300; i++) begin
      @(negedge clk);
      if (i == 5) begin
        tests_run++;
        if (bus_idle !== 1'b0) begin tests_failed++; $display("FAIL stuff_err_not_idle: got bus_idle=%b, expected 0", bus_idle); end
      end
      if (bus_idle && idle_lat == 0) idle_lat = i;
    end
    tests_run++;
    if (idle_lat < 1050 || idle_lat > 1110) begin
      tests_failed++;
      $display("FAIL stuff_err_reintegrate: got bus_idle at %0d clk, expected 1050..1110", idle_lat);
    end
  endtask

  task automatic test_glitch();
    int s0 = sof_cnt;
    int d0 = dv_cnt;
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    tests_run++;
    if (bus_idle !== 1'b0) begin tests_failed++; $display("FAIL glitch_in_frame: got bus_idle=%b, expected 0", bus_idle); end
    repeat (100) @(negedge clk);
    tests_run++;
    if (bus_idle !== 1'b1) begin tests_failed++; $display("FAIL glitch_back_idle: got bus_idle=%b, expected 1", bus_idle); end
    check_int("glitch_sof_count", sof_cnt - s0, 1);
    check_int("glitch_no_dvalid", dv_cnt - d0, 0);
  endtask

  task automatic test_drift();
    int d0 = dv_cnt;
    for (int i = 0; i < 20; i++) begin
      if (i == 1) sample_en = 1'b1;
      send_bit((i % 2 == 0) ? 1'b0 : 1'b1, 1'b1, 102);
    end
    sample_en = 1'b0;
    repeat (5) @(negedge clk);
    check_int("drift_dvalid_count", dv_cnt - d0, 20);
    check_int("drift_queue_empty", exp_q.size(), 0);
    tests_run++;
    if (bus_idle !== 1'b1) begin tests_failed++; $display("FAIL drift_end_idle: got bus_idle=%b, expected 1", bus_idle); end
  endtask

  task automatic test_reset_midframe();
    int d0 = dv_cnt;
    send_bit(1'b0, 1'b1, 100);
    sample_en = 1'b1;
    send_bit(1'b1, 1'b1, 100);
    send_bit(1'b0, 1'b1, 100);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (din !== 1'b1) begin tests_failed++; $display("FAIL midrst_din: got %b, expected 1", din); end
    tests_run++;
    if (dvalid !== 1'b0) begin tests_failed++; $display("FAIL midrst_dvalid: got %b, expected 0", dvalid); end
    tests_run++;
    if (bus_idle !== 1'b0) begin tests_failed++; $display("FAIL midrst_bus_idle: got %b, expected 0", bus_idle); end
    @(negedge clk);
    rst_n = 1'b1; sample_en = 1'b0;
    for (int i = 0; i < 6; i++) send_bit((i % 2 == 0) ? 1'b0 : 1'b1, 1'b0, 100);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check_int("midrst_dvalid_count", dv_cnt - d0, 3);
    check_int("midrst_queue_empty", exp_q.size(), 0);
    tests_run++;
    if (bus_idle !== 1'b0) begin tests_failed++; $display("FAIL midrst_still_integrating: got bus_idle=%b, expected 0", bus_idle); end
  endtask

  initial begin
    rst_n = 1'b0; rx = 1'b1; sample_en = 1'b0; destuff_en = 1'b1;
    @(negedge clk);
    test_reset();
    test_integrate();
    test_frame();
    test_destuff();
    test_stuff_err();
    test_glitch();
    test_drift();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
